fir_coef_ram_sched: RTL

Scheduler that shares the FIR coefficient single-port SRAM between a host coefficient-update port and the filter's per-sample coefficient fetch. On each sample strobe it bursts through taps 1..TAPS and streams coefficients with tap index to the MAC datapath. Between bursts it grants host writes. It sits between the coefficient loader and the filter core and solely drives the SRAM's chip-select, write-enable, address and write-data pins.

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_coef_fetch_cnt.sv | 28 ++
 rtl/fir_coef_ram_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default widths, coefficient-scheduler state encoding
// and the SRAM address-width rule.
package fir_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_DEPTH_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } schedState_t;

  // Depth is never a power of two, so the top word address fits in $clog2(depth) bits.
  function automatic int addrWidth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fir_coef_fetch_cnt.sv
// Tap counter running 1..TAPS: load restarts at 1, enable advances, wraps after TAPS.
module fir_coef_fetch_cnt
  import fir_pkg::*;
#(
  parameter int AW   = 4,
  parameter int TAPS = 10
) (
  input  logic          iClk_12M,
  input  logic          iRsn,
  input  logic          iLoad,
  input  logic          iEn,
  output logic [AW-1:0] oCnt,
  output logic          oTc
);

  assign oTc = (oCnt == AW'(TAPS));

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oCnt <= '0;
    end else if (iLoad) begin
      oCnt <= AW'(1);
    end else if (iEn) begin
      oCnt <= oTc ? AW'(1) : oCnt + AW'(1);
    end
  end

endmodule

// File: rtl/fir_coef_ram_sched.sv
// Arbitrates the single-port coefficient SRAM between per-sample tap bursts
// (highest priority) and host coefficient writes granted between bursts.
module fir_coef_ram_sched
  import fir_pkg::*;
#(
  parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int  ADDR_DEPTH = ADDR_DEPTH_DEF,
  parameter int  TAPS       = 10,
  localparam int AW         = addrWidth(ADDR_DEPTH)
) (
  input  logic                         iClk_12M,
  input  logic                         iRsn,
  input  logic                         iEnSample,
  input  logic                         iUpdVld,
  input  logic [AW-1:0]                iUpdAddr,
  input  logic signed [DATA_WIDTH-1:0] iUpdDt,
  output logic                         oUpdRdy,
  input  logic                         iClrErr,
  output logic                         oCsnRam,
  output logic                         oWrnRam,
  output logic [AW-1:0]                oAddrRam,
  output logic signed [DATA_WIDTH-1:0] oWrDtRam,
  input  logic signed [DATA_WIDTH-1:0] iRdDtRam,
  output logic signed [DATA_WIDTH-1:0] oCoef,
  output logic                         oCoefVld,
  output logic [AW-1:0]                oTapIdx,
  output logic                         oLastTap,
  output logic                         oBusy,
  output logic                         oOvr,
  output logic                         oAddrErr
);

  if ((ADDR_DEPTH & (ADDR_DEPTH - 1)) == 0) begin : gBadDepth
    $error("ADDR_DEPTH must not be a power of two");
  end
  if (TAPS < 1 || TAPS > ADDR_DEPTH) begin : gBadTaps
    $error("TAPS must lie in 1..ADDR_DEPTH");
  end

  schedState_t   state;
  logic [AW-1:0] tapCnt;
  logic          tapTc;
  logic          startFetch;
  logic          updAccept;
  logic          updLegal;

  // DRAIN carries no SRAM access, so a new sample may start there without a bubble.
  assign startFetch = iEnSample && (state == IDLE || state == DRAIN);
  assign oUpdRdy    = iRsn && (state == IDLE) && !iEnSample;
  assign updAccept  = iUpdVld && oUpdRdy;
  assign updLegal   = (iUpdAddr != '0) && (iUpdAddr <= AW'(ADDR_DEPTH));
  assign oCoef      = iRdDtRam;

  fir_coef_fetch_cnt #(
    .AW   (AW),
    .TAPS (TAPS)
  ) uTapCnt (
    .iClk_12M (iClk_12M),
    .iRsn     (iRsn),
    .iLoad    (startFetch),
    .iEn      (state == FETCH && !tapTc),
    .oCnt     (tapCnt),
    .oTc      (tapTc)
  );

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state    <= IDLE;
      oCsnRam  <= 1'b1;
      oWrnRam  <= 1'b1;
      oAddrRam <= '0;
      oWrDtRam <= '0;
      oCoefVld <= 1'b0;
      oTapIdx  <= '0;
      oLastTap <= 1'b0;
      oBusy    <= 1'b0;
      oOvr     <= 1'b0;
      oAddrErr <= 1'b0;
    end else begin
      // NOTE: these defaults are overridden further down; with non-blocking
      // assignments the last write in the block wins, so every path is covered.
      oCsnRam  <= 1'b1;
      oWrnRam  <= 1'b1;
      oCoefVld <= 1'b0;
      oLastTap <= 1'b0;

      case (state)
        IDLE, DRAIN: begin
          if (startFetch) begin
            state    <= FETCH;
            oBusy    <= 1'b1;
            oCsnRam  <= 1'b0;
            oAddrRam <= AW'(1);
          end else begin
            state <= IDLE;
            oBusy <= 1'b0;
            if (updAccept && updLegal) begin
              oCsnRam  <= 1'b0;
              oWrnRam  <= 1'b0;
              oAddrRam <= iUpdAddr;
              oWrDtRam <= iUpdDt;
            end
          end
        end
        FETCH: begin
          // Read data for tapCnt returns next cycle, so the index travels with it.
          oCoefVld <= 1'b1;
          oTapIdx  <= tapCnt;
          oLastTap <= tapTc;
          if (tapTc) begin
            state <= DRAIN;
          end else begin
            oCsnRam  <= 1'b0;
            oAddrRam <= tapCnt + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (iEnSample && state == FETCH) begin
        oOvr <= 1'b1;
      end else if (iClrErr) begin
        oOvr <= 1'b0;
      end

      if (updAccept && !updLegal) begin
        oAddrErr <= 1'b1;
      end else if (iClrErr) begin
        oAddrErr <= 1'b0;
      end
    end
  end

endmodule
